// File: rtl/i2c_adc_emu_if.sv
// ---------------------------------------------------------------------------
// i2c_adc_emu_if
// Two-wire bus bundle between an I2C master (or bus model) and the ADC
// emulator slave. SDA is open-drain: the slave never drives a level, it only
// requests a pull-down through sda_oe_o and the board/bench resolves the
// wired-AND onto sda_i.
//   scl_i    : bus clock as seen by the slave (asynchronous to the slave clock)
//   sda_i    : resolved bus data as seen by the slave (asynchronous)
//   sda_oe_o : 1 = slave pulls SDA low, 0 = slave releases SDA
// ---------------------------------------------------------------------------
interface i2c_adc_emu_if;
    logic scl_i;
    logic sda_i;
    logic sda_oe_o;

    modport master (output scl_i, output sda_i, input sda_oe_o);
    modport slave  (input scl_i, input sda_i, output sda_oe_o);
endinterface

// File: rtl/i2c_adc_emu.sv
// ---------------------------------------------------------------------------
// i2c_adc_emu
// Emulates a small I2C ADC: a 2-bit register pointer selects a read-only
// conversion register (0), a config register (1) or two reserved registers
// (2, 3). Conversions are mocked by latching one of the ch_data_i samples
// after CONV_CYCLES clocks, either single-shot (OS bit) or continuously.
//   clk_i       : system clock, everything on its rising edge
//   rst_i       : synchronous active-high reset
//   bus         : I2C slave side (scl_i, sda_i in, sda_oe_o out)
//   ch_data_i   : mock sample per channel, channel k at [16k+15:16k]
//   cfg_o       : current config register
//   busy_o      : conversion in progress
//   conv_done_o : one-cycle pulse when the conversion register updates
// ---------------------------------------------------------------------------
module i2c_adc_emu #(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h49,
    parameter int          N_CH        = 4,
    parameter int          CONV_CYCLES = 1000,
    parameter logic [15:0] CFG_RST     = 16'h8583
) (
    input  logic                clk_i,
    input  logic                rst_i,
    i2c_adc_emu_if.slave        bus,
    input  logic [16*N_CH-1:0]  ch_data_i,
    output logic [15:0]         cfg_o,
    output logic                busy_o,
    output logic                conv_done_o
);

    localparam int              CNT_W   = $clog2(CONV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CONV_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WMSB, ACK_WMSB, WLSB, ACK_WLSB,
        RMSB, MACK_MSB, RLSB, MACK_LSB, WAIT_STOP
    } state_t;

    // Bus synchronisers and previous synchronised values for edge detection
    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [7:0]  rx_sh;
    logic [6:0]  tx_sh;     // remaining bits of the byte being transmitted
    logic [7:0]  wmsb;
    logic [15:0] snap;      // read snapshot, frozen for the whole transaction
    logic [1:0]  ptr;
    logic        rw;
    logic        mack;      // SDA level seen in the master ACK slot
    logic        sda_oe;

    logic [15:0] conv_reg;
    logic [CNT_W-1:0] conv_cnt;
    logic [15:0] rd_val;
    logic [15:0] wdata;
    logic        commit_cfg;
    logic        next_single;
    logic        start_conv;
    logic        rx_state, cnt_state;

    // Sample of the channel selected by MUX=cfg[14:12]; channels that do
    // not exist read as zero.
    function automatic logic [15:0] sel_sample(input logic [15:0] cfg,
                                               input logic [16*N_CH-1:0] data);
        logic [1:0]  ch;
        logic [15:0] res;
        ch  = cfg[14] ? cfg[13:12] : 2'd0;
        res = 16'h0000;
        for (int k = 0; k < N_CH; k++) begin
            if (ch == k[1:0]) res = data[16*k +: 16];
        end
        return res;
    endfunction

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

    assign rx_state  = (state == ADDR) || (state == PTR) ||
                       (state == WMSB) || (state == WLSB);
    assign cnt_state = rx_state || (state == RMSB) || (state == RLSB);

    assign bus.sda_oe_o = sda_oe;

    always_comb begin
        rd_val = 16'h0000;
        case (ptr)
            2'd0:    rd_val = conv_reg;
            2'd1:    rd_val = {~busy_o, cfg_o[14:0]};
            default: rd_val = 16'h0000;
        endcase
    end

    // The data word commits on the SCL fall that ends the ACK of its LSB.
    // Only the config register is writable; other targets are ACKed and dropped.
    assign wdata      = {wmsb, rx_sh};
    assign commit_cfg = (state == ACK_WLSB) && scl_fall && (ptr == 2'd1);
    assign next_single = commit_cfg ? wdata[8] : cfg_o[8];
    assign start_conv = (commit_cfg && (wdata[15] || !wdata[8])) ||
                        (conv_done_o && !next_single);

    // Bus-side FSM
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_s1  <= 1'b1;
            scl_s2  <= 1'b1;
            scl_d   <= 1'b1;
            sda_s1  <= 1'b1;
            sda_s2  <= 1'b1;
            sda_d   <= 1'b1;
            state   <= IDLE;
            bit_cnt <= 4'd0;
            rx_sh   <= 8'h00;
            tx_sh   <= 7'h00;
            wmsb    <= 8'h00;
            snap    <= 16'h0000;
            ptr     <= 2'd0;
            rw      <= 1'b0;
            mack    <= 1'b1;
            sda_oe  <= 1'b0;
        end else begin
            scl_s1 <= bus.scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= bus.sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;

            if (start_det) begin
                state   <= ADDR;
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                sda_oe <= 1'b0;
            end else begin
                if (scl_rise && cnt_state) bit_cnt <= bit_cnt + 4'd1;
                if (scl_rise && rx_state)  rx_sh   <= {rx_sh[6:0], sda_s2};

                case (state)
                    ADDR: if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        if (rx_sh[7:1] == SLAVE_ADDR) begin
                            rw     <= rx_sh[0];
                            sda_oe <= 1'b1;
                            state  <= ACK_ADDR;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    ACK_ADDR: if (scl_fall) begin
                        bit_cnt <= 4'd0;
                        if (rw) begin
                            snap   <= rd_val;
                            tx_sh  <= rd_val[14:8];
                            sda_oe <= ~rd_val[15];
                            state  <= RMSB;
                        end else begin
                            sda_oe <= 1'b0;
                            state  <= PTR;
                        end
                    end
                    PTR: if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        sda_oe  <= 1'b1;
                        state   <= ACK_PTR;
                    end
                    ACK_PTR: if (scl_fall) begin
                        ptr    <= rx_sh[1:0];
                        sda_oe <= 1'b0;
                        state  <= WMSB;
                    end
                    WMSB: if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        wmsb    <= rx_sh;
                        sda_oe  <= 1'b1;
                        state   <= ACK_WMSB;
                    end
                    ACK_WMSB: if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WLSB;
                    end
                    WLSB: if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt <= 4'd0;
                        sda_oe  <= 1'b1;
                        state   <= ACK_WLSB;
                    end
                    ACK_WLSB: if (scl_fall) begin
                        sda_oe <= 1'b0;
                        state  <= WAIT_STOP;
                    end
                    RMSB, RLSB: if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            sda_oe  <= 1'b0;
                            state   <= (state == RMSB) ? MACK_MSB : MACK_LSB;
                        end else begin
                            sda_oe <= ~tx_sh[6];
                            tx_sh  <= {tx_sh[5:0], 1'b0};
                        end
                    end
                    MACK_MSB, MACK_LSB: begin
                        if (scl_rise) mack <= sda_s2;
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (!mack) begin
                                // Master ACK: keep streaming the same snapshot
                                if (state == MACK_MSB) begin
                                    tx_sh  <= snap[6:0];
                                    sda_oe <= ~snap[7];
                                    state  <= RLSB;
                                end else begin
                                    tx_sh  <= snap[14:8];
                                    sda_oe <= ~snap[15];
                                    state  <= RMSB;
                                end
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= WAIT_STOP;
                            end
                        end
                    end
                    IDLE, WAIT_STOP: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Config register and conversion engine
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_o       <= CFG_RST;
            busy_o      <= 1'b0;
            conv_done_o <= 1'b0;
            conv_cnt    <= '0;
            conv_reg    <= 16'h0000;
        end else begin
            conv_done_o <= 1'b0;
            // OS is an action bit: it is never kept in the stored register
            if (commit_cfg) cfg_o <= {1'b0, wdata[14:0]};

            if (busy_o) begin
                if (conv_cnt == '0) begin
                    conv_reg    <= sel_sample(cfg_o, ch_data_i);
                    conv_done_o <= 1'b1;
                    busy_o      <= 1'b0;
                end else begin
                    conv_cnt <= conv_cnt - 1'b1;
                end
            end else if (start_conv) begin
                busy_o   <= 1'b1;
                conv_cnt <= CNT_MAX;
            end
        end
    end

endmodule

// File: tb/tb_i2c_adc_emu.sv
`timescale 1ns/1ps
module tb_i2c_adc_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_scl, m_sda;
    logic [63:0] ch_data;
    logic [15:0] cfg;
    logic        busy, conv_done;

    int vectors = 0;
    int miscompares = 0;

    // Free-running monitor counters (written only here)
    int cyc = 0, busy_cyc = 0, done_cnt = 0, oe_cnt = 0;
    int last_done = 0, prev_done_at = 0;

    i2c_adc_emu_if bus();
    assign bus.scl_i = m_scl;
    assign bus.sda_i = m_sda & ~bus.sda_oe_o;

    i2c_adc_emu #(
        .SLAVE_ADDR (7'h49),
        .N_CH       (4),
        .CONV_CYCLES(1000),
        .CFG_RST    (16'h8583)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .ch_data_i  (ch_data),
        .cfg_o      (cfg),
        .busy_o     (busy),
        .conv_done_o(conv_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        if (bus.sda_oe_o) oe_cnt <= oe_cnt + 1;
        if (conv_done) begin
            done_cnt     <= done_cnt + 1;
            prev_done_at <= last_done;
            last_done    <= cyc;
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(5);
        m_scl = 1'b1; tick(10);
        m_sda = 1'b0; tick(10);
        m_scl = 1'b0; tick(5);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(5);
        m_scl = 1'b1; tick(10);
        m_sda = 1'b1; tick(10);
    endtask

    task automatic wr_ack(input string tag, input logic [7:0] b, input logic exp_ack);
        logic ack;
        for (int i = 7; i >= 0; i--) begin
            m_sda = b[i]; tick(5);
            m_scl = 1'b1; tick(10);
            m_scl = 1'b0; tick(5);
        end
        m_sda = 1'b1; tick(5);
        m_scl = 1'b1; tick(5);
        ack = ~bus.sda_i;
        tick(5);
        m_scl = 1'b0; tick(5);
        check(tag, ack, exp_ack);
    endtask

    task automatic rd_chk(input string tag, input logic give_ack, input logic [7:0] exp);
        logic [7:0] b;
        b = 8'h00;
        m_sda = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(5);
            m_scl = 1'b1; tick(5);
            b = {b[6:0], bus.sda_i};
            tick(5);
            m_scl = 1'b0;
        end
        tick(5);
        m_sda = give_ack ? 1'b0 : 1'b1; tick(5);
        m_scl = 1'b1; tick(10);
        m_scl = 1'b0; tick(5);
        m_sda = 1'b1;
        check(tag, b, exp);
    endtask

    task automatic wait_done(input string tag, input int base);
        int n;
        n = 0;
        while (done_cnt == base && n < 3000) begin
            tick(1);
            n++;
        end
        check(tag, (done_cnt != base), 1);
    endtask

    initial begin
        int b0, d0, o0;
        rst   = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        ch_data = {16'h3333, 16'h2222, 16'h4CCE, 16'h6990};
        tick(5);
        check("rst_cfg",  cfg, 16'h8583);
        check("rst_busy", busy, 0);
        check("rst_done", conv_done, 0);
        check("rst_oe",   bus.sda_oe_o, 0);
        rst = 1'b0;
        tick(5);

        // Single-shot conversion on channel 0
        b0 = busy_cyc; d0 = done_cnt;
        i2c_start();
        wr_ack("w_addr", 8'h92, 1);
        wr_ack("w_ptr",  8'h01, 1);
        wr_ack("w_msb",  8'hC3, 1);
        wr_ack("w_lsb",  8'h83, 1);
        i2c_stop();
        check("w_cfg",  cfg, 16'h4383);
        check("w_busy", busy, 1);
        wait_done("w_done_seen", d0);
        tick(5);
        check("w_busy_cycles", busy_cyc - b0, 1000);
        check("w_done_count",  done_cnt - d0, 1);

        // Read conversion register via repeated START
        i2c_start();
        wr_ack("r0_waddr", 8'h92, 1);
        wr_ack("r0_ptr",   8'h00, 1);
        i2c_start();
        wr_ack("r0_raddr", 8'h93, 1);
        rd_chk("r0_msb", 1, 8'h69);
        rd_chk("r0_lsb", 0, 8'h90);
        i2c_stop();

        // Read config while idle: OS reads 1, read wraps with master ACK
        i2c_start();
        wr_ack("r1_waddr", 8'h92, 1);
        wr_ack("r1_ptr",   8'h01, 1);
        i2c_start();
        wr_ack("r1_raddr", 8'h93, 1);
        rd_chk("r1_msb",  1, 8'hC3);
        rd_chk("r1_lsb",  1, 8'h83);
        rd_chk("r1_wrap", 0, 8'hC3);
        i2c_stop();

        // Other slave address: no ACK, SDA never pulled
        o0 = oe_cnt;
        i2c_start();
        wr_ack("x_addr", 8'h94, 0);
        wr_ack("x_data", 8'h01, 0);
        i2c_stop();
        check("x_oe_quiet", oe_cnt - o0, 0);
        check("x_cfg",      cfg, 16'h4383);

        // Aborted write (MSB only) leaves config untouched
        i2c_start();
        wr_ack("a_addr", 8'h92, 1);
        wr_ack("a_ptr",  8'h01, 1);
        wr_ack("a_msb",  8'h12, 1);
        i2c_stop();
        check("a_cfg", cfg, 16'h4383);

        // Start a conversion, then read config while busy: OS reads 0
        d0 = done_cnt;
        i2c_start();
        wr_ack("b_addr", 8'h92, 1);
        wr_ack("b_ptr",  8'h01, 1);
        wr_ack("b_msb",  8'hC3, 1);
        wr_ack("b_lsb",  8'h83, 1);
        i2c_stop();
        i2c_start();
        wr_ack("b_raddr", 8'h93, 1);
        rd_chk("b_msb_busy", 1, 8'h43);
        rd_chk("b_lsb_busy", 0, 8'h83);
        i2c_stop();
        check("b_still_busy", busy, 1);
        wait_done("b_done_seen", d0);
        tick(5);

        // Continuous conversion on channel 1
        d0 = done_cnt;
        i2c_start();
        wr_ack("c_addr", 8'h92, 1);
        wr_ack("c_ptr",  8'h01, 1);
        wr_ack("c_msb",  8'hD2, 1);
        wr_ack("c_lsb",  8'h83, 1);
        i2c_stop();
        check("c_cfg", cfg, 16'h5283);
        wait_done("c_done1", d0);
        ch_data[31:16] = 16'h1234;
        d0 = done_cnt;
        wait_done("c_done2", d0);
        d0 = done_cnt;
        wait_done("c_done3", d0);
        tick(2);
        check("c_period", last_done - prev_done_at, 1001);
        i2c_start();
        wr_ack("c_waddr", 8'h92, 1);
        wr_ack("c_rptr",  8'h00, 1);
        i2c_start();
        wr_ack("c_raddr", 8'h93, 1);
        rd_chk("c_msb", 1, 8'h12);
        rd_chk("c_lsb", 0, 8'h34);
        i2c_stop();

        // Reset in the middle of an MSB read
        i2c_start();
        wr_ack("z_raddr", 8'h93, 1);
        check("z_driving", bus.sda_oe_o, 1);
        rst = 1'b1;
        tick(1);
        check("z_oe",   bus.sda_oe_o, 0);
        check("z_cfg",  cfg, 16'h8583);
        check("z_busy", busy, 0);
        check("z_done", conv_done, 0);
        rst = 1'b0;
        tick(3);
        i2c_stop();
        i2c_start();
        wr_ack("z_waddr", 8'h92, 1);
        wr_ack("z_wptr",  8'h01, 1);
        wr_ack("z_wmsb",  8'h85, 1);
        wr_ack("z_wlsb",  8'h83, 1);
        i2c_stop();
        check("z_cfg_new", cfg, 16'h0583);
        i2c_start();
        wr_ack("z_paddr", 8'h92, 1);
        wr_ack("z_pptr",  8'h00, 1);
        i2c_start();
        wr_ack("z_rdaddr", 8'h93, 1);
        rd_chk("z_conv_msb", 1, 8'h00);
        rd_chk("z_conv_lsb", 0, 8'h00);
        i2c_stop();
        check("z_busy_new", busy, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_adc_emu.md
I2C_ADC_EMU -- requirements
Module: i2c_adc_emu

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h49, 7-bit I2C address matched.
REQ-002 SHALL have parameter N_CH, default 4, number of emulated input channels (1..4).
REQ-003 SHALL have parameter CONV_CYCLES, default 1000, clk_i cycles per conversion (>=2).
REQ-004 SHALL have parameter CFG_RST, default 16'h8583, reset value of config register.
REQ-005 clk_i  input  1  single system clock; all logic on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 scl_i  input  1  I2C clock from bus, asynchronous.
REQ-008 sda_i  input  1  I2C data from bus, asynchronous.
REQ-009 sda_oe_o  output  1  1 = pull SDA low, 0 = release (external tristate).
REQ-010 ch_data_i  input  16*N_CH  mock sample per channel, channel k at [16k+15:16k].
REQ-011 cfg_o  output  16  current config register.
REQ-012 busy_o  output  1  conversion in progress.
REQ-013 conv_done_o  output  1  one-cycle pulse when conversion register updates.

Function
REQ-014 scl_i, sda_i SHALL pass 2-flop synchronisers; edges and START/STOP detected on the synchronised values only.
REQ-015 START = sda fall while scl high; STOP = sda rise while scl high; both SHALL be honoured in every FSM state.
REQ-016 Bit sampling on synchronised scl rise; sda_oe_o changes only on the cycle after a synchronised scl fall.
REQ-017 FSM states: IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WMSB, ACK_WMSB, WLSB, ACK_WLSB, RMSB, MACK_MSB, RLSB, MACK_LSB, WAIT_STOP.
REQ-018 IDLE/any state + START -> ADDR, bit counter cleared; STOP -> IDLE, sda_oe_o=0.
REQ-019 ADDR: shift 8 bits MSB first; address mismatch -> WAIT_STOP, no ACK; match -> ACK_ADDR (drive low one SCL period).
REQ-020 After ACK_ADDR: R/W=0 -> PTR; R/W=1 -> RMSB with 16-bit read snapshot of register selected by pointer.
REQ-021 PTR: byte[1:0] stored as pointer, ACKed; then WMSB; WMSB, WLSB each ACKed; at end of ACK_WLSB the 16-bit word commits to pointer target, then -> WAIT_STOP.
REQ-022 STOP or repeated START before ACK_WLSB completes SHALL leave registers unchanged (pointer still updated if ACK_PTR done).
REQ-023 Pointer 0 = conversion (read-only, writes ignored but ACKed); 1 = config; 2, 3 = read 16'h0000, writes ignored but ACKed.
REQ-024 Read: RMSB sends snapshot[15:8], RLSB sends [7:0], MSB first, released for master ACK; ACK after LSB wraps to RMSB with same snapshot; NACK at either -> WAIT_STOP.
REQ-025 Config bit 15 (OS) read returns ~busy; written 1 while idle starts conversion; written 1 while busy ignored; stored OS bit otherwise not retained.
REQ-026 Channel select: MUX=cfg[14:12]; MUX>=4 -> ch=MUX[1:0], else ch=0; ch>=N_CH -> result 16'h0000.
REQ-027 Conversion: busy_o high for CONV_CYCLES cycles from cycle after commit; last cycle latches selected ch_data_i into conversion register, pulses conv_done_o, clears busy_o.
REQ-028 cfg[8]=0 (continuous): new conversion SHALL start the cycle after each completion, and immediately on commit of cfg[8]=0; cfg[8]=1 single-shot.
REQ-029 Config write during conversion updates cfg_o immediately; MUX sampled at completion.
REQ-030 Read snapshot never torn: conversion completing mid-read does not alter bytes of that transaction.

Reset
REQ-031 rst_i high SHALL force IDLE, sda_oe_o=0, pointer=0, conversion=16'h0000, cfg_o=CFG_RST, busy_o=0, conv_done_o=0, including mid-transaction.
REQ-032 After reset release, bus traffic already in progress SHALL be ignored until next START.

Verification
REQ-033 Write 0x92,0x01,0xC3,0x83 (ptr1, OS=1 MUX=4 single) -> 4 ACKs, cfg_o=0x4383, busy_o for 1000 cycles, conv_done_o once, conversion=ch_data_i[15:0].
REQ-034 After REQ-033 with ch0=16'h6990: write 0x92,0x00, repeated START, read 0x93 two bytes master ACK then NACK -> 0x69, 0x90.
REQ-035 Address 0x94 (other slave) -> no ACK, sda_oe_o=0 throughout, registers unchanged.
REQ-036 Config 0xD283 (MUX=5, continuous), ch1 changes 0x4CCE->0x1234 -> successive conv_done_o every 1001 cycles, conversion tracks 0x1234.
REQ-037 Write ptr1 + MSB only then STOP -> cfg_o unchanged; read of ptr1 while busy -> bit15=0.
REQ-038 rst_i asserted mid-RMSB -> sda_oe_o=0 next cycle, all outputs at reset values, next full transaction succeeds.
